// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Upstream sequencer for a 4:1 bit multiplexer. It steps the mux select through
// the four channels and holds each channel for SETTLE_CYCLES settle cycles plus
// one sample cycle. It samples the mux output into a work register and then
// presents the assembled 4-bit word on a valid/ready output port. Both
// single-shot and continuous scanning are supported.
//
// Optional feature macro: MUX_SCAN_MASK_EN
//   When it is defined, a ch_mask input is added. It is captured when start is
//   accepted, and disabled channels are skipped entirely. Their data bits read 0.
//
// Parameters
//   SETTLE_CYCLES : settle cycles per channel before sampling (legal 1..15)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a scan (honoured only while idle)
//   mode     in   0 = single scan, 1 = continuous (captured with start)
//   stop     in   end continuous scanning after the current scan
//   sel      out  channel select to mux S (registered)
//   mux_en   out  mux enable to mux EN (registered)
//   mux_y    in   mux output Y
//   data     out  assembled word, bit i = channel i sample
//   valid    out  data holds an unconsumed word
//   ready    in   consumer accepts data when valid && ready
//   busy     out  sequencer is not idle (registered)
//   ch_mask  in   channel enable mask (only with MUX_SCAN_MASK_EN)
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       stop,
    output logic [1:0] sel,
    output logic       mux_en,
    input  logic       mux_y,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [3:0] ch_mask,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The counter is loaded with SETTLE_CYCLES-1 and counts down to 0. This
    // gives exactly SETTLE_CYCLES cycles in SETTLE.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Return the lowest enabled channel in mask.
    function automatic logic [1:0] first_ch(input logic [3:0] mask);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                ch = 2'(i);
            end else begin
                ch = ch;
            end
        end
        return ch;
    endfunction

    // Return 1 when some enabled channel lies above cur.
    function automatic logic has_next(input logic [3:0] mask, input logic [1:0] cur);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && (i > int'(cur))) begin
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

    // Return the lowest enabled channel above cur. The loop walks downward, so
    // the last hit is the nearest channel above cur.
    function automatic logic [1:0] next_ch(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] ch;
        ch = cur;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                ch = 2'(i);
            end else begin
                ch = ch;
            end
        end
        return ch;
    endfunction

    state_t     state_r;
    logic [1:0] sel_r;
    logic       mux_en_r;
    logic [3:0] data_r;
    logic       valid_r;
    logic       busy_r;
    logic [3:0] work_r;
    logic [3:0] cnt_r;
    logic       mode_r;
    logic       stop_r;

    logic [3:0] mask_s;       // channel mask in force for the running session
    logic [3:0] start_mask_s; // mask that would be captured by an accepted start
    logic [3:0] word_s;       // work register with the current sample merged in
    logic       last_s;       // current channel is the last enabled one
    logic       can_xfer_s;   // output register can take a new word this cycle
    logic       go_on_s;      // another scan follows the one now completing

`ifdef MUX_SCAN_MASK_EN
    logic [3:0] mask_r;

    // Select the captured mask for the session and the live mask for start.
    always_comb begin
        mask_s       = mask_r;
        start_mask_s = ch_mask;
    end
`else
    // Without the mask feature, every channel is always scanned.
    always_comb begin
        mask_s       = 4'b1111;
        start_mask_s = 4'b1111;
    end
`endif

    // Merge the mux sample into the work word, and decode the scan-control conditions.
    always_comb begin
        word_s        = work_r;
        word_s[sel_r] = mux_y;
        last_s        = !has_next(mask_s, sel_r);
        can_xfer_s    = !valid_r || ready;
        // A stop that arrives on the completing edge still counts. The latch
        // has not been updated yet at that point.
        go_on_s       = mode_r && !(stop_r || stop);
    end

    // Scan sequencer FSM with registered mux controls, output word and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            sel_r    <= 2'd0;
            mux_en_r <= 1'b0;
            data_r   <= 4'd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            work_r   <= 4'd0;
            cnt_r    <= 4'd0;
            mode_r   <= 1'b0;
            stop_r   <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
            mask_r   <= 4'd0;
`endif
        end else begin
            // The consumer takes the word. A transfer in the same cycle
            // overrides this below and keeps valid high.
            if (valid_r && ready) begin
                valid_r <= 1'b0;
            end

            if ((state_r != IDLE) && stop) begin
                stop_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    sel_r    <= 2'd0;
                    mux_en_r <= 1'b0;
                    if (start && (start_mask_s != 4'd0)) begin
                        mode_r   <= mode;
                        stop_r   <= 1'b0;
                        work_r   <= 4'd0;
`ifdef MUX_SCAN_MASK_EN
                        mask_r   <= start_mask_s;
`endif
                        sel_r    <= first_ch(start_mask_s);
                        mux_en_r <= 1'b1;
                        cnt_r    <= SETTLE_LOAD;
                        busy_r   <= 1'b1;
                        state_r  <= SETTLE;
                    end
                end

                SETTLE: begin
                    mux_en_r <= 1'b1;
                    if (cnt_r == 4'd0) begin
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end

                SAMPLE: begin
                    work_r <= word_s;
                    if (!last_s) begin
                        sel_r   <= next_ch(mask_s, sel_r);
                        cnt_r   <= SETTLE_LOAD;
                        state_r <= SETTLE;
                    end else if (can_xfer_s) begin
                        data_r  <= word_s;
                        valid_r <= 1'b1;
                        if (go_on_s) begin
                            sel_r    <= first_ch(mask_s);
                            mux_en_r <= 1'b1;
                            cnt_r    <= SETTLE_LOAD;
                            work_r   <= 4'd0;
                            state_r  <= SETTLE;
                        end else begin
                            sel_r    <= 2'd0;
                            mux_en_r <= 1'b0;
                            busy_r   <= 1'b0;
                            stop_r   <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        // The consumer has not taken the previous word yet.
                        // Park with sel unchanged and the mux disabled.
                        mux_en_r <= 1'b0;
                        state_r  <= HOLD;
                    end
                end

                HOLD: begin
                    mux_en_r <= 1'b0;
                    if (ready) begin
                        data_r  <= work_r;
                        valid_r <= 1'b1;
                        if (go_on_s) begin
                            sel_r    <= first_ch(mask_s);
                            mux_en_r <= 1'b1;
                            cnt_r    <= SETTLE_LOAD;
                            work_r   <= 4'd0;
                            state_r  <= SETTLE;
                        end else begin
                            sel_r    <= 2'd0;
                            busy_r   <= 1'b0;
                            stop_r   <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end
                end

                default: begin
                    sel_r    <= 2'd0;
                    mux_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                    stop_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign sel    = sel_r;
    assign mux_en = mux_en_r;
    assign data   = data_r;
    assign valid  = valid_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Directed testbench for mux_scan_ctrl with SETTLE_CYCLES = 2.
// A behavioural 4:1 mux is built from the vector x:
//   mux_y = mux_en ? x[sel] : 0.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, before any new inputs are driven. Cycle k is counted from the rising
// edge E that accepts start: the falling edge in cycle k lies between edges
// E+k-1 and E+k.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic       stop;
    logic [1:0] sel;
    logic       mux_en;
    logic       mux_y;
    logic [3:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic [3:0] x;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0] ch_mask;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mux_y = mux_en ? x[sel] : 1'b0;

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .stop   (stop),
        .sel    (sel),
        .mux_en (mux_en),
        .mux_y  (mux_y),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(ch_mask),
`endif
        .busy   (busy)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (sel !== 2'd0)    begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        total++; if (mux_en !== 1'b0) begin bad++; $display("FAIL reset_mux_en got=%0b exp=0", mux_en); end
        total++; if (data !== 4'd0)   begin bad++; $display("FAIL reset_data got=%b exp=0000", data); end
        total++; if (valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        x = 4'b1010; mode = 1'b0; ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (mux_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL reset_presettle got=%0b%0b exp=11", mux_en, busy); end
        // Reset asserted in the middle of SETTLE.
        #2 rst_n = 1'b0;
        #1;
        total++; if ({sel, mux_en, valid, busy} !== 5'b00000) begin bad++; $display("FAIL reset_midscan got=%b exp=00000", {sel, mux_en, valid, busy}); end
        @(negedge clk);
        total++; if ({sel, mux_en, valid, busy} !== 5'b00000) begin bad++; $display("FAIL reset_nextcycle got=%b exp=00000", {sel, mux_en, valid, busy}); end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_noword k=%0d valid=%0b busy=%0b exp=0 0", k, valid, busy); end
        end
    endtask

    task automatic test_single;
        x = 4'b1010; mode = 1'b0; ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            total++; if (sel !== 2'((k - 1) / 3)) begin bad++; $display("FAIL single_sel k=%0d got=%0d exp=%0d", k, sel, (k - 1) / 3); end
            total++; if (mux_en !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_ctl k=%0d got=%0b%0b%0b exp=101", k, mux_en, valid, busy); end
        end
        @(negedge clk);
        total++; if (valid !== 1'b1)   begin bad++; $display("FAIL single_valid got=%0b exp=1", valid); end
        total++; if (data !== 4'b1010) begin bad++; $display("FAIL single_data got=%b exp=1010", data); end
        total++; if (busy !== 1'b0 || mux_en !== 1'b0 || sel !== 2'd0) begin bad++; $display("FAIL single_idle busy=%0b mux_en=%0b sel=%0d exp=0 0 0", busy, mux_en, sel); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_consumed got=%0b exp=0", valid); end
    endtask

    task automatic test_back_to_back;
        bit done;
        x = 4'b1010; mode = 1'b1; ready = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        @(negedge clk); // k = 13
        total++; if (valid !== 1'b1 || data !== 4'b1010) begin bad++; $display("FAIL bp_first valid=%0b data=%b exp=1 1010", valid, data); end
        total++; if (busy !== 1'b1 || mux_en !== 1'b1 || sel !== 2'd0) begin bad++; $display("FAIL bp_restart busy=%0b mux_en=%0b sel=%0d exp=1 1 0", busy, mux_en, sel); end
        x = 4'b0101;
        for (int k = 14; k <= 24; k++) @(negedge clk);
        @(negedge clk); // k = 25, in HOLD
        total++; if (mux_en !== 1'b0 || sel !== 2'd3 || busy !== 1'b1) begin bad++; $display("FAIL bp_hold mux_en=%0b sel=%0d busy=%0b exp=0 3 1", mux_en, sel, busy); end
        total++; if (valid !== 1'b1 || data !== 4'b1010) begin bad++; $display("FAIL bp_hold_data valid=%0b data=%b exp=1 1010", valid, data); end
        repeat (2) @(negedge clk);
        total++; if (data !== 4'b1010 || mux_en !== 1'b0) begin bad++; $display("FAIL bp_hold_stable data=%b mux_en=%0b exp=1010 0", data, mux_en); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        total++; if (valid !== 1'b1 || data !== 4'b0101) begin bad++; $display("FAIL bp_release valid=%0b data=%b exp=1 0101", valid, data); end
        total++; if (mux_en !== 1'b1 || sel !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL bp_resume mux_en=%0b sel=%0d busy=%0b exp=1 0 1", mux_en, sel, busy); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL bp_drain_timeout busy=%0b exp=0", busy); end
        total++; if (valid !== 1'b1 || data !== 4'b0101) begin bad++; $display("FAIL bp_last valid=%0b data=%b exp=1 0101", valid, data); end
        @(negedge clk);
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_end valid=%0b busy=%0b exp=0 0", valid, busy); end
    endtask

    task automatic test_stop;
        int words;
        words = 0;
        x = 4'b1010; mode = 1'b1; ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (valid === 1'b1) words++;
            if (k == 13) begin
                total++; if (valid !== 1'b1 || data !== 4'b1010) begin bad++; $display("FAIL stop_word1 valid=%0b data=%b exp=1 1010", valid, data); end
            end
            if (k == 24) begin
                total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL stop_pre busy=%0b valid=%0b exp=1 0", busy, valid); end
            end
            if (k == 25) begin
                total++; if (busy !== 1'b0 || valid !== 1'b1 || data !== 4'b1010) begin bad++; $display("FAIL stop_word2 busy=%0b valid=%0b data=%b exp=0 1 1010", busy, valid, data); end
            end
            stop = (k == 16);
        end
        total++; if (words != 2) begin bad++; $display("FAIL stop_words got=%0d exp=2", words); end
    endtask

    task automatic test_simultaneous;
        x = 4'b0110; mode = 1'b1; ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 6) begin
                total++; if (sel !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL sim_start_ignored sel=%0d busy=%0b exp=1 1", sel, busy); end
            end
            if (k == 13) begin
                total++; if (valid !== 1'b1 || data !== 4'b0110) begin bad++; $display("FAIL sim_word valid=%0b data=%b exp=1 0110", valid, data); end
                total++; if (busy !== 1'b0 || mux_en !== 1'b0) begin bad++; $display("FAIL sim_idle busy=%0b mux_en=%0b exp=0 0", busy, mux_en); end
            end
            if (k == 16) begin
                total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL sim_quiet busy=%0b valid=%0b exp=0 0", busy, valid); end
            end
            start = (k == 5);
            stop  = (k == 12);
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask;
        x = 4'b1111; ch_mask = 4'b0101; mode = 1'b0; ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            total++; if (sel !== ((k <= 3) ? 2'd0 : 2'd2)) begin bad++; $display("FAIL mask_sel k=%0d got=%0d", k, sel); end
        end
        @(negedge clk);
        total++; if (valid !== 1'b1 || data !== 4'b0101 || busy !== 1'b0) begin bad++; $display("FAIL mask_word valid=%0b data=%b busy=%0b exp=1 0101 0", valid, data, busy); end
        ch_mask = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || mux_en !== 1'b0) begin bad++; $display("FAIL mask_zero busy=%0b mux_en=%0b exp=0 0", busy, mux_en); end
        ch_mask = 4'b1111;
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0; ready = 1'b0; x = 4'b0000;
`ifdef MUX_SCAN_MASK_EN
        ch_mask = 4'b1111;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_stop();
        test_simultaneous();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
